// File: rtl/hamming_secded_codec.sv
// Two-stage pipelined Hamming SECDED codec: per-word encode or decode with
// single-error correction, double-error detection and saturating error counters.
module hamming_secded_codec #(
  parameter int unsigned DATA_W = 11,
  parameter int unsigned PAR_W  = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_mode,
  input  logic [DATA_W+PAR_W:0]   in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W+PAR_W:0]   out_data,
  output logic                    out_mode,
  output logic                    out_err_single,
  output logic                    out_err_double,
  output logic [PAR_W-1:0]        out_syndrome,
  input  logic                    clr_cnt,
  output logic [CNT_W-1:0]        corr_cnt,
  output logic [CNT_W-1:0]        uncorr_cnt
);

  localparam int unsigned N      = DATA_W + PAR_W;
  localparam int unsigned CODE_W = N + 1;

  if ((32'd1 << PAR_W) < DATA_W + PAR_W + 1) begin : g_param_check
    $error("hamming_secded_codec: PAR_W too small for DATA_W");
  end

  function automatic logic is_pow2(input int unsigned i);
    return ((i & (i - 32'd1)) == 32'd0);
  endfunction

  function automatic logic [PAR_W-1:0] syndrome_f(input logic [N-1:0] cw);
    logic [PAR_W-1:0] s;
    s = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      if (cw[i-1]) s = s ^ PAR_W'(i);
    end
    return s;
  endfunction

  // Data bits occupy the non-power-of-two positions, LSB first.
  function automatic logic [N-1:0] place_f(input logic [DATA_W-1:0] d);
    logic [N-1:0] cw;
    int unsigned  k;
    cw = '0;
    k  = 0;
    for (int unsigned i = 1; i <= N; i++) begin
      if (!is_pow2(i) && k < DATA_W) begin
        cw[i-1] = d[k];
        k++;
      end
    end
    return cw;
  endfunction

  function automatic logic [DATA_W-1:0] extract_f(input logic [N-1:0] cw);
    logic [DATA_W-1:0] d;
    int unsigned       k;
    d = '0;
    k = 0;
    for (int unsigned i = 1; i <= N; i++) begin
      if (!is_pow2(i) && k < DATA_W) begin
        d[k] = cw[i-1];
        k++;
      end
    end
    return d;
  endfunction

  // With check positions still zero, the syndrome bits are exactly the check bits.
  function automatic logic [CODE_W-1:0] encode_f(input logic [DATA_W-1:0] d);
    logic [N-1:0]     cw;
    logic [PAR_W-1:0] s;
    cw = place_f(d);
    s  = syndrome_f(cw);
    for (int unsigned k = 0; k < PAR_W; k++) begin
      if ((32'd1 << k) <= N) cw[(32'd1 << k) - 32'd1] = s[k];
    end
    return {^cw, cw};
  endfunction

  logic                adv;
  logic                s1_valid_q, s1_mode_q;
  logic [CODE_W-1:0]   s1_data_q;
  logic                out_valid_q, out_mode_q, err_single_q, err_double_q;
  logic [CODE_W-1:0]   out_data_q, out_data_d;
  logic [PAR_W-1:0]    syndrome_q, syndrome_d;
  logic                err_single_d, err_double_d;
  logic [CNT_W-1:0]    corr_cnt_q, uncorr_cnt_q;
  logic [PAR_W-1:0]    syn;
  logic                par;
  logic [N-1:0]        fixed;
  logic [CODE_W-1:0]   flip;

  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;

  // Stage-2 result from the stage-1 word.
  always_comb begin
    syn          = syndrome_f(s1_data_q[N-1:0]);
    par          = ^s1_data_q;
    fixed        = s1_data_q[N-1:0];
    flip         = CODE_W'(1) << syn;
    out_data_d   = '0;
    err_single_d = 1'b0;
    err_double_d = 1'b0;
    syndrome_d   = '0;
    if (!s1_mode_q) begin
      out_data_d = encode_f(s1_data_q[DATA_W-1:0]);
    end else begin
      syndrome_d = syn;
      if (par) begin
        // syn == 0 means only the overall-parity bit flipped; flip[N:1] is then zero.
        if (32'(syn) <= N) begin
          fixed        = fixed ^ flip[N:1];
          err_single_d = 1'b1;
        end else begin
          err_double_d = 1'b1;
        end
      end else if (syn != '0) begin
        err_double_d = 1'b1;
      end
      out_data_d = CODE_W'(extract_f(fixed));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_mode_q    <= 1'b0;
      s1_data_q    <= '0;
      out_valid_q  <= 1'b0;
      out_mode_q   <= 1'b0;
      out_data_q   <= '0;
      err_single_q <= 1'b0;
      err_double_q <= 1'b0;
      syndrome_q   <= '0;
    end else if (adv) begin
      s1_valid_q   <= in_valid;
      s1_mode_q    <= in_mode;
      s1_data_q    <= in_data;
      out_valid_q  <= s1_valid_q;
      out_mode_q   <= s1_mode_q;
      out_data_q   <= out_data_d;
      err_single_q <= err_single_d;
      err_double_q <= err_double_d;
      syndrome_q   <= syndrome_d;
    end
  end

  // Saturating error statistics; clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else if (clr_cnt) begin
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else if (out_valid_q && out_ready) begin
      if (err_single_q && corr_cnt_q != '1)   corr_cnt_q   <= corr_cnt_q + CNT_W'(1);
      if (err_double_q && uncorr_cnt_q != '1) uncorr_cnt_q <= uncorr_cnt_q + CNT_W'(1);
    end
  end

  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;
  assign out_mode       = out_mode_q;
  assign out_err_single = err_single_q;
  assign out_err_double = err_double_q;
  assign out_syndrome   = syndrome_q;
  assign corr_cnt       = corr_cnt_q;
  assign uncorr_cnt     = uncorr_cnt_q;

endmodule

// File: tb/tb_hamming_secded_codec.sv
// Directed bench for hamming_secded_codec (DATA_W=11, PAR_W=4, CNT_W=4).
module tb_hamming_secded_codec;

  localparam int unsigned DATA_W = 11;
  localparam int unsigned PAR_W  = 4;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned CODE_W = DATA_W + PAR_W + 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid, in_ready, in_mode;
  logic [CODE_W-1:0] in_data;
  logic              out_valid, out_ready, out_mode;
  logic [CODE_W-1:0] out_data;
  logic              out_err_single, out_err_double;
  logic [PAR_W-1:0]  out_syndrome;
  logic              clr_cnt;
  logic [CNT_W-1:0]  corr_cnt, uncorr_cnt;

  int errors = 0;
  int checks = 0;
  logic [CNT_W-1:0] exp_corr   = '0;
  logic [CNT_W-1:0] exp_uncorr = '0;

  logic [CODE_W-1:0] enc_in  [4] = '{16'h07FF, 16'h0000, 16'h0001, 16'hF801};
  logic [CODE_W-1:0] enc_exp [4] = '{16'hFFFF, 16'h0000, 16'h8007, 16'h8007};

  logic [CODE_W-1:0] dec_in   [4] = '{16'hFFEF, 16'h0007, 16'hFFFC, 16'h8007};
  logic [CODE_W-1:0] dec_exp  [4] = '{16'h07FF, 16'h0001, 16'h07FF, 16'h0001};
  logic              dec_sgl  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  logic              dec_dbl  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  logic [PAR_W-1:0]  dec_syn  [4] = '{4'd5, 4'd0, 4'd3, 4'd0};

  logic              bb_mode [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [CODE_W-1:0] bb_in   [4] = '{16'h07FF, 16'hFFEF, 16'h0001, 16'hFFFC};
  logic [CODE_W-1:0] bb_exp  [4] = '{16'hFFFF, 16'h07FF, 16'h8007, 16'h07FF};
  logic              bb_sgl  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  logic              bb_dbl  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  logic              bp_mode [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic [CODE_W-1:0] bp_in   [4] = '{16'h0007, 16'h0000, 16'hFFEF, 16'h07FF};
  logic [CODE_W-1:0] bp_exp  [4] = '{16'h0001, 16'h0000, 16'h07FF, 16'hFFFF};
  logic              bp_sgl  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic              bp_pat  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  hamming_secded_codec #(.DATA_W(DATA_W), .PAR_W(PAR_W), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_mode        (in_mode),
    .in_data        (in_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_mode       (out_mode),
    .out_err_single (out_err_single),
    .out_err_double (out_err_double),
    .out_syndrome   (out_syndrome),
    .clr_cnt        (clr_cnt),
    .corr_cnt       (corr_cnt),
    .uncorr_cnt     (uncorr_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Presents one word for a single accepted cycle; caller ensures in_ready=1.
  task automatic drive_word(input logic m, input logic [CODE_W-1:0] d);
    in_valid = 1'b1;
    in_mode  = m;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_mode  = 1'b0;
    in_data  = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_mode = 1'b0; in_data = '0;
    out_ready = 1'b1; clr_cnt = 1'b0;
    #2;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b out_data=%h required 1 0 0000", in_ready, out_valid, out_data);
    end
    checks++;
    if (corr_cnt !== '0 || uncorr_cnt !== '0) begin
      errors++;
      $display("FAIL reset_counters: corr=%h uncorr=%h required 0 0", corr_cnt, uncorr_cnt);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL after_reset: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_encode();
    for (int i = 0; i < 4; i++) begin
      drive_word(1'b0, enc_in[i]);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL enc_latency[%0d]: out_valid=%b one clock after handshake, required 0", i, out_valid);
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== enc_exp[i] || out_mode !== 1'b0) begin
        errors++;
        $display("FAIL enc_data[%0d]: valid=%b data=%h mode=%b required 1 %h 0", i, out_valid, out_data, out_mode, enc_exp[i]);
      end
      checks++;
      if (out_err_single !== 1'b0 || out_err_double !== 1'b0 || out_syndrome !== '0) begin
        errors++;
        $display("FAIL enc_flags[%0d]: single=%b double=%b syn=%h required 0 0 0", i, out_err_single, out_err_double, out_syndrome);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_decode();
    for (int i = 0; i < 4; i++) begin
      drive_word(1'b1, dec_in[i]);
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== dec_exp[i] || out_mode !== 1'b1) begin
        errors++;
        $display("FAIL dec_data[%0d]: valid=%b data=%h mode=%b required 1 %h 1", i, out_valid, out_data, out_mode, dec_exp[i]);
      end
      checks++;
      if (out_err_single !== dec_sgl[i] || out_err_double !== dec_dbl[i] || out_syndrome !== dec_syn[i]) begin
        errors++;
        $display("FAIL dec_flags[%0d]: single=%b double=%b syn=%h required %b %b %h", i, out_err_single, out_err_double, out_syndrome, dec_sgl[i], dec_dbl[i], dec_syn[i]);
      end
      if (dec_sgl[i]) exp_corr = exp_corr + 4'd1;
      if (dec_dbl[i]) exp_uncorr = exp_uncorr + 4'd1;
      @(posedge clk); #1;
      checks++;
      if (corr_cnt !== exp_corr || uncorr_cnt !== exp_uncorr) begin
        errors++;
        $display("FAIL dec_counters[%0d]: corr=%h uncorr=%h required %h %h", i, corr_cnt, uncorr_cnt, exp_corr, exp_uncorr);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 6; c++) begin
      if (c < 4) begin
        in_valid = 1'b1; in_mode = bb_mode[c]; in_data = bb_in[c];
      end else begin
        in_valid = 1'b0; in_mode = 1'b0; in_data = '0;
      end
      checks++;
      if (out_valid !== (c >= 2)) begin
        errors++;
        $display("FAIL b2b_valid[%0d]: out_valid=%b required %b", c, out_valid, (c >= 2));
      end
      if (c >= 2) begin
        checks++;
        if (out_data !== bb_exp[c-2] || out_mode !== bb_mode[c-2] ||
            out_err_single !== bb_sgl[c-2] || out_err_double !== bb_dbl[c-2]) begin
          errors++;
          $display("FAIL b2b_data[%0d]: data=%h mode=%b s=%b d=%b required %h %b %b %b", c-2, out_data, out_mode,
                   out_err_single, out_err_double, bb_exp[c-2], bb_mode[c-2], bb_sgl[c-2], bb_dbl[c-2]);
        end
        if (bb_sgl[c-2]) exp_corr = exp_corr + 4'd1;
        if (bb_dbl[c-2]) exp_uncorr = exp_uncorr + 4'd1;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (corr_cnt !== exp_corr || uncorr_cnt !== exp_uncorr) begin
      errors++;
      $display("FAIL b2b_counters: corr=%h uncorr=%h required %h %h", corr_cnt, uncorr_cnt, exp_corr, exp_uncorr);
    end
  endtask

  task automatic test_backpressure();
    int                sent = 0;
    int                recv = 0;
    int                cyc  = 0;
    logic              held = 1'b0;
    logic [CODE_W-1:0] held_data = '0;
    logic              held_mode = 1'b0;
    while (recv < 4 && cyc < 40) begin
      out_ready = bp_pat[cyc % 4];
      in_valid  = (sent < 4);
      if (sent < 4) begin
        in_mode = bp_mode[sent];
        in_data = bp_in[sent];
      end
      #1;
      checks++;
      if (in_ready !== (!out_valid || out_ready)) begin
        errors++;
        $display("FAIL bp_in_ready[cyc %0d]: in_ready=%b required %b", cyc, in_ready, (!out_valid || out_ready));
      end
      if (held) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== held_data || out_mode !== held_mode) begin
          errors++;
          $display("FAIL bp_stable[cyc %0d]: valid=%b data=%h mode=%b required 1 %h %b", cyc, out_valid, out_data, out_mode, held_data, held_mode);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (out_data !== bp_exp[recv] || out_mode !== bp_mode[recv] || out_err_single !== bp_sgl[recv]) begin
          errors++;
          $display("FAIL bp_order[%0d]: data=%h mode=%b single=%b required %h %b %b", recv, out_data, out_mode,
                   out_err_single, bp_exp[recv], bp_mode[recv], bp_sgl[recv]);
        end
        if (bp_sgl[recv]) exp_corr = exp_corr + 4'd1;
        recv++;
      end
      held      = out_valid && !out_ready;
      held_data = out_data;
      held_mode = out_mode;
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; in_mode = 1'b0; in_data = '0; out_ready = 1'b1;
    checks++;
    if (recv != 4 || sent != 4) begin
      errors++;
      $display("FAIL bp_count: sent=%0d received=%0d within %0d cycles, required 4 4", sent, recv, cyc);
    end
    checks++;
    if (corr_cnt !== exp_corr || uncorr_cnt !== exp_uncorr) begin
      errors++;
      $display("FAIL bp_counters: corr=%h uncorr=%h required %h %h", corr_cnt, uncorr_cnt, exp_corr, exp_uncorr);
    end
  endtask

  task automatic test_counters();
    clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    exp_corr = '0; exp_uncorr = '0;
    checks++;
    if (corr_cnt !== '0 || uncorr_cnt !== '0) begin
      errors++;
      $display("FAIL cnt_clear: corr=%h uncorr=%h required 0 0", corr_cnt, uncorr_cnt);
    end
    // Seventeen corrected words push a 4-bit counter past its ceiling.
    for (int c = 0; c < 19; c++) begin
      in_valid = (c < 17);
      in_mode  = 1'b1;
      in_data  = 16'hFFEF;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_mode = 1'b0; in_data = '0;
    checks++;
    if (corr_cnt !== 4'hF || uncorr_cnt !== 4'h0) begin
      errors++;
      $display("FAIL cnt_saturate: corr=%h uncorr=%h required f 0", corr_cnt, uncorr_cnt);
    end
    drive_word(1'b1, 16'hFFEF);
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_err_single !== 1'b1) begin
      errors++;
      $display("FAIL cnt_clr_setup: out_valid=%b single=%b required 1 1", out_valid, out_err_single);
    end
    clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    checks++;
    if (corr_cnt !== 4'h0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL cnt_clr_priority: corr=%h out_valid=%b required 0 0", corr_cnt, out_valid);
    end
  endtask

  task automatic test_reset_midstream();
    drive_word(1'b1, 16'hFFEF);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (corr_cnt !== 4'h1) begin
      errors++;
      $display("FAIL rst_setup_cnt: corr=%h required 1", corr_cnt);
    end
    in_valid = 1'b1; in_mode = 1'b1; in_data = 16'hFFFC;
    @(posedge clk); #1;
    in_mode = 1'b0; in_data = 16'h07FF;
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = '0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_err_double !== 1'b1) begin
      errors++;
      $display("FAIL rst_setup_full: out_valid=%b double=%b required 1 1", out_valid, out_err_double);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_err_double !== 1'b0 || out_mode !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_async_out: valid=%b data=%h double=%b mode=%b in_ready=%b required 0 0000 0 0 1",
               out_valid, out_data, out_err_double, out_mode, in_ready);
    end
    checks++;
    if (corr_cnt !== '0 || uncorr_cnt !== '0) begin
      errors++;
      $display("FAIL rst_async_cnt: corr=%h uncorr=%h required 0 0", corr_cnt, uncorr_cnt);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_discard: out_valid=%b after release, required 0", out_valid);
    end
    drive_word(1'b0, 16'h07FF);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_new_latency: out_valid=%b required 0", out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'hFFFF) begin
      errors++;
      $display("FAIL rst_new_enc: valid=%b data=%h required 1 ffff", out_valid, out_data);
    end
  endtask

  initial begin
    test_reset();
    test_encode();
    test_decode();
    test_back_to_back();
    test_backpressure();
    test_counters();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hamming_secded_codec.md
Name: hamming_secded_codec

Overview:
- Parametrised, pipelined Hamming SECDED codec that encodes or decodes one word per transaction.
- The mode is selected per transaction. Decoding corrects single-bit errors and detects double-bit errors.
- Successor to the fixed 11/15 combinational encoder: adds a decode path, an extra overall-parity bit, valid/ready streaming and error statistics counters.
- Sits between the CPU datapath and the protected storage or link.

Parameters:
- DATA_W, 11: data bits per word.
- PAR_W, 4: Hamming check bits. Elaboration fails unless 2^PAR_W >= DATA_W+PAR_W+1.
- CNT_W, 16: width of the error counters.
- Derived: N = DATA_W+PAR_W (Hamming positions); CODE_W = N+1.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input word valid
- in_ready  out  1  codec can accept input
- in_mode  in  1  0=encode, 1=decode; sampled with the input handshake
- in_data  in  CODE_W  encode uses [DATA_W-1:0] and ignores the rest; decode takes the full codeword
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  CODE_W  encode: codeword; decode: corrected data in [DATA_W-1:0], upper bits 0
- out_mode  out  1  mode of the result
- out_err_single  out  1  decode: single error corrected
- out_err_double  out  1  decode: uncorrectable error
- out_syndrome  out  PAR_W  decode: raw syndrome
- clr_cnt  in  1  synchronous counter clear
- corr_cnt  out  CNT_W  count of corrected words
- uncorr_cnt  out  CNT_W  count of uncorrectable words

Behaviour:
- Codeword layout:
  - codeword bit i-1 holds Hamming position i, for i = 1..N.
  - Check bits sit at power-of-two positions; check bit 2^k is the XOR of all positions with bit k set.
  - Data bits fill the remaining positions in ascending order, data LSB at the lowest position (position 3).
  - Bit CODE_W-1 is overall even parity over bits [N-1:0].
- Pipeline:
  - Two register stages. S1 registers the input and computes the syndrome S and overall parity P. S2 registers the corrected result and flags.
  - Latency is 2 clocks from the input handshake to out_valid when there is no backpressure.
  - Global advance enable adv = !out_valid || out_ready; in_ready = adv.
  - On adv: S1 captures in_valid && in_ready, and S2 captures the S1 contents.
  - With adv=0, every stage holds, and out_* stay stable while out_valid=1 and out_ready=0.
  - Sustains 1 word/clk with out_ready held at 1.
- Decode rules:
  - S=0, P=0: no error; both flags 0.
  - P=1, 1<=S<=N: flip position S and set err_single.
  - P=1, S=0: the overall-parity bit is in error; data unchanged; set err_single.
  - P=1, S>N: set err_double; data passed uncorrected.
  - P=0, S!=0: set err_double; data passed uncorrected.
- Encode: flags and syndrome output 0.
- Counters:
  - On each output handshake (out_valid && out_ready): corr_cnt += err_single and uncorr_cnt += err_double.
  - Both counters saturate at all-ones.
  - clr_cnt zeroes both counters and has priority over a same-cycle increment.
- Reset:
  - Asserting rst_n low clears both stages' valid bits, out_data, flags, syndrome, out_mode and both counters to 0 immediately, at any point, mid-stream included.
  - in_ready reads 1 during and after reset.
  - Words in flight are discarded.

Test Plan:
- Encode, DATA_W=11: 11'h7FF -> 16'hFFFF; 11'h000 -> 16'h0000; 11'h001 -> 16'h8007. Each appears 2 clocks after its handshake; flags 0.
- Decode 16'hFFEF (position 5 flipped) -> data 11'h7FF, err_single=1, syndrome 5, corr_cnt 0->1.
- Decode 16'h0007 (overall-parity bit flipped) -> data 11'h001, err_single=1, syndrome 0. Decode 16'hFFFC (positions 1,2 flipped) -> err_double=1, syndrome 3, uncorr_cnt increments.
- Backpressure: stream 4 mixed words with out_ready toggling 1,0,0,1 -> in_ready follows adv, no loss or duplication, out_* stable while stalled, order preserved.
- Counters: preload corr_cnt to all-ones through repeated single errors (CNT_W=4 build) -> holds at 4'hF. clr_cnt with a concurrent single-error handshake -> counter reads 0.
- Pull rst_n low with both stages valid -> out_valid=0 and counters 0 immediately. After release, a new encode of 11'h7FF yields 16'hFFFF after 2 clocks.
